// File: rtl/ast_packet_arbiter.sv
// ast_packet_arbiter: packet-atomic round-robin merge of NUM_SRC Avalon-ST sinks
// onto one fully registered Avalon-ST source; the winner's index rides on the channel field.
module ast_packet_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 2
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic [NUM_SRC*DATA_W-1:0]    snk_ast_data,
  input  logic [NUM_SRC-1:0]           snk_ast_startofpacket,
  input  logic [NUM_SRC-1:0]           snk_ast_endofpacket,
  input  logic [NUM_SRC-1:0]           snk_ast_valid,
  input  logic [NUM_SRC*EMPTY_W-1:0]   snk_ast_empty,
  output logic [NUM_SRC-1:0]           snk_ast_ready,
  output logic [DATA_W-1:0]            src_ast_data,
  output logic                         src_ast_startofpacket,
  output logic                         src_ast_endofpacket,
  output logic                         src_ast_valid,
  output logic [EMPTY_W-1:0]           src_ast_empty,
  output logic [CHANNEL_W-1:0]         src_ast_channel,
  input  logic                         src_ast_ready
);
  localparam int IDX_W = $clog2(NUM_SRC);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_gnt, r_rr_ptr, w_pick;
  logic             w_any, w_rdy, w_acc, w_eop;
  // Walk from the far end toward rr_ptr so the nearest valid index wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (snk_ast_valid[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
        w_any  = 1'b1;
        w_pick = IDX_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      end
    end
  end
  assign w_rdy         = (r_state == LOCK) && (!src_ast_valid || src_ast_ready);
  assign w_acc         = w_rdy && snk_ast_valid[r_gnt];
  assign w_eop         = snk_ast_endofpacket[r_gnt];
  assign snk_ast_ready = w_rdy ? (NUM_SRC'(1) << r_gnt) : '0;
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_any ? LOCK : IDLE) : ((w_acc && w_eop) ? IDLE : LOCK);
  end
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      r_gnt                 <= '0;
      r_rr_ptr              <= '0;
      src_ast_valid         <= 1'b0;
      src_ast_data          <= '0;
      src_ast_startofpacket <= 1'b0;
      src_ast_endofpacket   <= 1'b0;
      src_ast_empty         <= '0;
      src_ast_channel       <= '0;
    end else begin
      if (r_state == IDLE && w_any) r_gnt <= w_pick;
      if (w_acc && w_eop) r_rr_ptr <= (r_gnt == IDX_W'(NUM_SRC - 1)) ? '0 : r_gnt + 1'b1;
      if (w_acc) begin
        src_ast_valid         <= 1'b1;
        src_ast_data          <= snk_ast_data[int'(r_gnt)*DATA_W +: DATA_W];
        src_ast_startofpacket <= snk_ast_startofpacket[r_gnt];
        src_ast_endofpacket   <= w_eop;
        src_ast_empty         <= snk_ast_empty[int'(r_gnt)*EMPTY_W +: EMPTY_W];
        src_ast_channel       <= CHANNEL_W'(r_gnt);
      end else if (src_ast_ready) begin
        src_ast_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ast_packet_arbiter.sv
// tb_ast_packet_arbiter: directed scoreboard bench; per-source beat queues feed the sinks,
// expected output beats are queued in predicted round-robin order and checked on the output.
module tb_ast_packet_arbiter;
  localparam int N = 4, DW = 64, EW = 3, CW = 2;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emp;
    logic [CW-1:0] ch;
  } beat_t;
  logic          clk = 1'b0;
  logic          srst;
  logic [N*DW-1:0] snk_ast_data;
  logic [N-1:0]  snk_ast_startofpacket, snk_ast_endofpacket, snk_ast_valid, snk_ast_ready;
  logic [N*EW-1:0] snk_ast_empty;
  logic [DW-1:0] src_ast_data;
  logic          src_ast_startofpacket, src_ast_endofpacket, src_ast_valid, src_ast_ready;
  logic [EW-1:0] src_ast_empty;
  logic [CW-1:0] src_ast_channel;
  beat_t sq[N][$];
  beat_t exp_q[$];
  int    out_cyc[$];
  bit    rdy_q[$];
  int    n_chk = 0, n_pass = 0, cyc = 0, n_stall = 0, n_extra = 0;

  ast_packet_arbiter #(.NUM_SRC(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) dut (
    .clk(clk), .srst(srst),
    .snk_ast_data(snk_ast_data), .snk_ast_startofpacket(snk_ast_startofpacket),
    .snk_ast_endofpacket(snk_ast_endofpacket), .snk_ast_valid(snk_ast_valid),
    .snk_ast_empty(snk_ast_empty), .snk_ast_ready(snk_ast_ready),
    .src_ast_data(src_ast_data), .src_ast_startofpacket(src_ast_startofpacket),
    .src_ast_endofpacket(src_ast_endofpacket), .src_ast_valid(src_ast_valid),
    .src_ast_empty(src_ast_empty), .src_ast_channel(src_ast_channel),
    .src_ast_ready(src_ast_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, src_ast_valid, 0);
    chk({tag, "_data"}, src_ast_data, 0);
    chk({tag, "_sop"}, src_ast_startofpacket, 0);
    chk({tag, "_eop"}, src_ast_endofpacket, 0);
    chk({tag, "_empty"}, src_ast_empty, 0);
    chk({tag, "_channel"}, src_ast_channel, 0);
    chk({tag, "_snk_ready"}, snk_ast_ready, 0);
  endtask

  function automatic beat_t mk(int ch, int len, int k, logic [DW-1:0] base, int emp);
    beat_t b;
    b.d   = base + DW'(k);
    b.sop = (k == 0);
    b.eop = (k == len - 1);
    b.emp = b.eop ? EW'(emp) : '0;
    b.ch  = CW'(ch);
    return b;
  endfunction

  task automatic src_pkt(int s, int len, logic [DW-1:0] base, int emp);
    for (int k = 0; k < len; k++) sq[s].push_back(mk(0, len, k, base, emp));
  endtask

  task automatic exp_pkt(int ch, int len, logic [DW-1:0] base, int emp);
    for (int k = 0; k < len; k++) exp_q.push_back(mk(ch, len, k, base, emp));
  endtask

  task automatic drain(string tag);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    chk(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Source drivers: present queue heads, retire a beat once it was seen accepted.
  initial begin
    logic [N-1:0] acc;
    beat_t b;
    snk_ast_valid = '0; snk_ast_data = '0; snk_ast_empty = '0;
    snk_ast_startofpacket = '0; snk_ast_endofpacket = '0; src_ast_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc = snk_ast_valid & snk_ast_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && sq[i].size() != 0) void'(sq[i].pop_front());
      for (int i = 0; i < N; i++) begin
        b = (sq[i].size() != 0) ? sq[i][0] : '0;
        snk_ast_valid[i]         = (sq[i].size() != 0);
        snk_ast_data[i*DW +: DW] = b.d;
        snk_ast_startofpacket[i] = b.sop;
        snk_ast_endofpacket[i]   = b.eop;
        snk_ast_empty[i*EW +: EW] = b.emp;
      end
      src_ast_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on every accepted beat, stability under stall.
  initial begin
    beat_t ob, e, hb;
    bit held;
    held = 1'b0;
    hb   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ob = {src_ast_data, src_ast_startofpacket, src_ast_endofpacket, src_ast_empty, src_ast_channel};
      if (srst && src_ast_valid && !src_ast_ready) begin
        n_stall++;
        chk("bp_snk_ready", snk_ast_ready, 0);
        if (held) chk("bp_hold", ob, hb);
        held = 1'b1;
        hb   = ob;
      end else held = 1'b0;
      if (srst && src_ast_valid && src_ast_ready) begin
        if (exp_q.size() == 0) n_extra++;
        else begin
          e = exp_q.pop_front();
          chk("beat", ob, e);
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    srst = 1'b1;
    #2 srst = 1'b0;
    #1 check_zero("rst");
    repeat (3) @(negedge clk);
    srst = 1'b1;
    @(posedge clk);
    // single source, two 4-beat packets
    out_cyc.delete();
    src_pkt(1, 4, 'h10, 5); src_pkt(1, 4, 'h10, 5);
    exp_pkt(1, 4, 'h10, 5); exp_pkt(1, 4, 'h10, 5);
    drain("single_drain");
    chk("single_count", out_cyc.size(), 8);
    chk("single_throughput", out_cyc[3] - out_cyc[0], 3);
    chk("single_gap", out_cyc[4] - out_cyc[3], 2);
    // fairness: pointer starts at 2 here, so first park it at 0 via source 3
    src_pkt(3, 1, 'h1f0, 0); exp_pkt(3, 1, 'h1f0, 0);
    drain("park_drain");
    src_pkt(0, 2, 'h100, 1); src_pkt(0, 2, 'h104, 1);
    src_pkt(1, 2, 'h110, 1); src_pkt(1, 2, 'h114, 1);
    src_pkt(2, 2, 'h120, 1); src_pkt(3, 2, 'h130, 1);
    exp_pkt(0, 2, 'h100, 1); exp_pkt(1, 2, 'h110, 1); exp_pkt(2, 2, 'h120, 1);
    exp_pkt(3, 2, 'h130, 1); exp_pkt(0, 2, 'h104, 1); exp_pkt(1, 2, 'h114, 1);
    drain("rr_drain");
    // wrap and skip: pointer back to 0 after source 3
    src_pkt(3, 1, 'h300, 0); exp_pkt(3, 1, 'h300, 0);
    drain("park2_drain");
    src_pkt(1, 2, 'h400, 2); src_pkt(1, 2, 'h402, 2);
    src_pkt(3, 2, 'h410, 2); src_pkt(3, 2, 'h412, 2);
    exp_pkt(1, 2, 'h400, 2); exp_pkt(3, 2, 'h410, 2);
    exp_pkt(1, 2, 'h402, 2); exp_pkt(3, 2, 'h412, 2);
    drain("wrap_drain");
    // single-beat packets from sources 0 and 2, pointer at 0
    out_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      src_pkt(0, 1, DW'('h500 + k), 2);
      src_pkt(2, 1, DW'('h520 + k), 2);
      exp_pkt(0, 1, DW'('h500 + k), 2);
      exp_pkt(2, 1, DW'('h520 + k), 2);
    end
    drain("sbeat_drain");
    chk("sbeat_count", out_cyc.size(), 6);
    for (int k = 0; k < 5; k++) chk("sbeat_spacing", out_cyc[k+1] - out_cyc[k], 2);
    // back-pressure on a 6-beat packet
    n_stall = 0;
    rdy_q = '{1, 1, 1, 0, 0, 1};
    src_pkt(0, 6, 'h600, 7); exp_pkt(0, 6, 'h600, 7);
    drain("bp_drain");
    chk("bp_stalls", n_stall, 2);
    // reset mid-packet: park pointer at 3 first so a stale pointer would pick source 3
    src_pkt(2, 2, 'h700, 1); exp_pkt(2, 2, 'h700, 1);
    drain("pre_rst_drain");
    src_pkt(3, 8, 'h800, 0); exp_pkt(3, 8, 'h800, 0);
    for (int k = 0; k < 100 && exp_q.size() > 6; k++) @(posedge clk);
    chk("mid_pkt", exp_q.size() <= 6 && exp_q.size() > 0, 1);
    @(negedge clk);
    #2 srst = 1'b0;
    #1 check_zero("midrst");
    for (int i = 0; i < N; i++) sq[i].delete();
    exp_q.delete();
    rdy_q.delete();
    repeat (2) @(posedge clk);
    src_pkt(3, 2, 'h900, 3); src_pkt(2, 2, 'h910, 4);
    exp_pkt(2, 2, 'h910, 4); exp_pkt(3, 2, 'h900, 3);
    @(negedge clk);
    srst = 1'b1;
    drain("post_rst_drain");
    chk("extra_beats", n_extra, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ast_packet_arbiter.md
# ast_packet_arbiter

Packet-atomic round-robin arbiter that merges NUM_SRC Avalon-ST sink streams onto one Avalon-ST source stream. It sits in front of the converter datapath so several producers can share one converter instance. Once a source wins, it holds the output until its end-of-packet beat is accepted. The winning source index is driven on the output channel field. The output stage is fully registered.

## Interface
- NUM_SRC, 4: number of sink ports, 2..16
- DATA_W, 64: data width per port
- EMPTY_W, 3: empty width per port
- CHANNEL_W, 2: output channel width, must be >= $clog2(NUM_SRC)
- clk  in  1  clock; all logic on the rising edge
- srst  in  1  reset, asynchronous, active-low
- snk_ast_data  in  NUM_SRC*DATA_W  flattened; port i occupies [i*DATA_W +: DATA_W]
- snk_ast_startofpacket  in  NUM_SRC  per-port SOP
- snk_ast_endofpacket  in  NUM_SRC  per-port EOP
- snk_ast_valid  in  NUM_SRC  per-port valid
- snk_ast_empty  in  NUM_SRC*EMPTY_W  flattened per-port empty
- snk_ast_ready  out  NUM_SRC  per-port ready
- src_ast_data  out  DATA_W  output data
- src_ast_startofpacket  out  1  output SOP
- src_ast_endofpacket  out  1  output EOP
- src_ast_valid  out  1  output valid
- src_ast_empty  out  EMPTY_W  output empty
- src_ast_channel  out  CHANNEL_W  index of the source that produced the beat, zero-extended
- src_ast_ready  in  1  downstream ready

## Operation
- States:
  - IDLE: no source owns the output.
  - LOCK: source `gnt_idx` owns the output.
- Round-robin pointer `rr_ptr`:
  - Range 0..NUM_SRC-1; reset value 0.
  - On each packet completion, set to (gnt_idx+1) mod NUM_SRC. It wraps from NUM_SRC-1 to 0.
- IDLE transition:
  - If any snk_ast_valid[i] is 1, load `gnt_idx` with the first asserted index searching rr_ptr, rr_ptr+1, … with wrap-around.
  - Go to LOCK on the next edge.
  - If no valid is asserted, remain in IDLE.
- The SOP flag is not checked for arbitration. The first beat accepted from a source is forwarded with its own SOP value unchanged.
- In LOCK:
  - snk_ast_ready[gnt_idx] = !src_ast_valid || src_ast_ready.
  - All other snk_ast_ready bits are 0.
- In IDLE, all snk_ast_ready bits are 0.
- Beat accept: snk_ast_valid[gnt_idx] && snk_ast_ready[gnt_idx]. On accept:
  - The output register loads data, SOP, EOP, empty and channel = gnt_idx.
  - src_ast_valid is set to 1.
- Output register clear: if src_ast_ready is 1 and no new beat is accepted in the same cycle, src_ast_valid goes to 0.
- Packet end: an accepted beat with EOP=1 moves LOCK to IDLE on the same edge and updates rr_ptr.
- A single-beat packet (SOP=EOP=1) locks and unlocks normally.
- Non-granted sources are never back-pressured beyond ready=0. Their valid and data may change freely.
- Reset value of every output is 0:
  - src_ast_valid, SOP, EOP, data, empty, channel, and all snk_ast_ready bits are 0.
  - Internally: state is IDLE, rr_ptr = 0, gnt_idx = 0.
- Reset mid-packet:
  - All outputs go to 0 immediately, asynchronously.
  - The partial packet is dropped and is not resumed.
  - After release, arbitration restarts from rr_ptr = 0.

## Timing
- Arbitration: a valid input in IDLE at cycle n gives LOCK at n+1, with snk_ast_ready asserted in n+1 if the output register is free.
- Data latency: a beat accepted at edge k appears on src_ast_* in the cycle after edge k, i.e. one register stage.
- Throughput: 1 beat/cycle while locked and src_ast_ready stays high.
- Packet gap:
  - The edge accepting EOP returns to IDLE.
  - The next grant is registered on the following edge.
  - Minimum one cycle with no input acceptance between consecutive packets.
- Back-pressure: with src_ast_ready=0 and src_ast_valid=1, snk_ast_ready[gnt_idx] is 0 combinationally in the same cycle. Output contents hold stable.
- The src_ast_* outputs are register-driven. snk_ast_ready is combinational from state and src_ast_ready only.

## Test plan
- **Reset:** assert srst=0 mid-stream.
  - All outputs read 0 within the same cycle.
  - After release with source 2 valid, the first output beat has channel=2 and the arbiter started from rr_ptr=0.
- **Single source:** source 1 sends 4-beat packets with data 0x10..0x13, empty=5 on EOP, src_ast_ready=1.
  - Output shows 0x10..0x13 with channel=1, SOP on beat 0, EOP+empty=5 on beat 3.
  - One-cycle gap between packets.
- **Round-robin fairness:** all 4 sources continuously valid with 2-beat packets.
  - Output channel order is 0,1,2,3,0,1.
  - No packet is interleaved with another.
- **Wrap and skip:** only sources 3 and 1 valid, starting from rr_ptr=0.
  - Grant order is 1,3,1,3; the pointer wraps 3→0 and skips idle sources.
- **Back-pressure:** src_ast_ready toggles 1,0,0,1 during a 6-beat packet from source 0.
  - No beat is lost or duplicated.
  - Output data/EOP hold stable while ready=0.
  - snk_ast_ready[0]=0 in those cycles.
- **Single-beat packets:** sources 0 and 2 send SOP=EOP=1 beats continuously.
  - Output alternates channel 0,2.
  - Each beat carries SOP=EOP=1.
  - One beat every 2 cycles.
